// File: rtl/drain_collector_if.sv
// Array-side drain bus and unified-buffer write port of the drain collector.
interface drain_collector_if #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  acc_in;
  logic                             drain_enable;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data;

  modport master (
    input  acc_in, wr_ready,
    output drain_enable, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output acc_in, wr_ready,
    input  drain_enable, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/drain_collector.sv
// Drains output-stationary accumulators from the systolic array into the unified buffer.
// Optional requantization (shift + saturate) is enabled by defining DRAIN_REQUANT_EN.
module drain_collector #(
  parameter int unsigned ARRAY_SIZE = 4,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [5:0]            shift,
  drain_collector_if.master     bus,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W    = $clog2(ARRAY_SIZE) + 1;
  localparam int unsigned LAST_ROW = ARRAY_SIZE - 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

  state_t                           state;
  logic [CNT_W-1:0]                 row_cnt;
  logic [ADDR_WIDTH-1:0]            base_q;
  logic [ADDR_WIDTH-1:0]            wr_addr_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data_q;
  logic                             wr_valid_q;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_data_c;
  logic                             drain_en_c;

`ifdef DRAIN_REQUANT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({(DATA_WIDTH-1){1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [5:0] shift_q;

  // Arithmetic shift then clamp into the signed output range
  function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc,
                                                    input logic [5:0]           sh);
    logic signed [ACC_WIDTH-1:0] s;
    s = $signed(acc) >>> sh;
    if (s > SAT_MAX)      requant = SAT_MAX[DATA_WIDTH-1:0];
    else if (s < SAT_MIN) requant = SAT_MIN[DATA_WIDTH-1:0];
    else                  requant = s[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    row_data_c = '0;
    for (int unsigned c = 0; c < ARRAY_SIZE; c++)
      row_data_c[c*DATA_WIDTH +: DATA_WIDTH] = requant(bus.acc_in[c*ACC_WIDTH +: ACC_WIDTH], shift_q);
  end
`else
  logic unused_bits;
  assign unused_bits = ^{shift, bus.acc_in};

  always_comb begin
    row_data_c = '0;
    for (int unsigned c = 0; c < ARRAY_SIZE; c++)
      row_data_c[c*DATA_WIDTH +: DATA_WIDTH] = bus.acc_in[c*ACC_WIDTH +: DATA_WIDTH];
  end
`endif

  // Shift the array only when the output register is free or being emptied this cycle
  assign drain_en_c = (state == S_DRAIN) && (!wr_valid_q || bus.wr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row_cnt    <= '0;
      base_q     <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DRAIN_REQUANT_EN
      shift_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
`ifdef DRAIN_REQUANT_EN
            shift_q <= shift;
`endif
            row_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Bottom row of the array arrives first, so addresses count down from the top
          if (drain_en_c) begin
            wr_data_q  <= row_data_c;
            wr_addr_q  <= base_q + ADDR_WIDTH'(LAST_ROW) - ADDR_WIDTH'(row_cnt);
            wr_valid_q <= 1'b1;
            row_cnt    <= row_cnt + CNT_W'(1);
            if (row_cnt == CNT_W'(LAST_ROW)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (wr_valid_q && bus.wr_ready) begin
            wr_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.drain_enable = drain_en_c;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;

endmodule

// File: tb/tb_drain_collector.sv
// Directed, table-driven bench for drain_collector with a bottom-edge array model.
module tb_drain_collector;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 16;
  localparam int unsigned ADW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [ADW-1:0] base_addr;
  logic [5:0]     shift;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  drain_collector_if #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_WIDTH(ADW)) bus ();

  drain_collector #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_WIDTH(ADW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .shift     (shift),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  // Array model: rows presented bottom-first, one step per drain_enable edge
  logic [AW-1:0] mat [N][N];
  int            ptr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= N - 1;
    else if (start && !busy)    ptr <= N - 1;
    else if (bus.drain_enable)  ptr <= ptr - 1;
  end

  always_comb begin
    bus.acc_in = '0;
    for (int c = 0; c < N; c++)
      if (ptr >= 0 && ptr < N) bus.acc_in[c*AW +: AW] = mat[ptr][c];
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] model_q(input logic [AW-1:0] a, input logic [5:0] sh);
`ifdef DRAIN_REQUANT_EN
    longint v;
    v = $signed(a) >>> sh;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
`else
    if (sh > 6'd63) return 16'h0;
    return a[15:0];
`endif
  endfunction

  function automatic logic [N*DW-1:0] model_row(input int r, input logic [5:0] sh);
    logic [N*DW-1:0] d;
    for (int c = 0; c < N; c++) d[c*DW +: DW] = model_q(mat[r][c], sh);
    return d;
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = AW'(100*r + c);
  endtask

  task automatic fill_const(input logic [AW-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = v;
  endtask

  // One full drain: optional stall on write stall_at, optional stray start pulses
  task automatic run_drain(input logic [ADW-1:0] base, input logic [5:0] sh,
                           input int stall_at, input int stall_len, input bit stray,
                           input int exp_done,
                           output logic [ADW-1:0] first_addr, output logic [N*DW-1:0] first_data);
    int cyc, k, stalled, de_cnt;
    bit fin;
    logic [ADW-1:0] ea;
    k = 0; stalled = 0; de_cnt = 0; fin = 0; cyc = 0;
    first_addr = '0; first_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = base; shift = sh; bus.wr_ready = 1'b1;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = (stray && cyc == 2);
      if (bus.wr_valid && k == stall_at && stalled < stall_len) begin
        bus.wr_ready = 1'b0;
        stalled++;
      end else begin
        bus.wr_ready = 1'b1;
      end
      if (stray && bus.wr_valid && bus.wr_ready && k == N - 1) start = 1'b1;
      #1;
      if (cyc == 1) check("busy_cycle1", 64'(busy), 64'd1);
      if (bus.drain_enable) de_cnt++;
      if (bus.wr_valid && k < N) begin
        ea = base + ADW'(N - 1 - k);
        check("wr_addr", 64'(bus.wr_addr), 64'(ea));
        check("wr_data", 64'(bus.wr_data), 64'(model_row(N - 1 - k, sh)));
        if (!bus.wr_ready) check("stall_drain_enable", 64'(bus.drain_enable), 64'd0);
        else begin
          if (k == 0) begin first_addr = bus.wr_addr; first_data = bus.wr_data; end
          k++;
        end
      end
      if (done) begin
        fin = 1'b1;
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("busy_at_done", 64'(busy), 64'd0);
        check("write_count", 64'(k), 64'(N));
        check("drain_enable_cycles", 64'(de_cnt), 64'(N));
      end
    end
    check("done_seen", 64'(fin), 64'd1);
    start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] acc;
    logic [5:0]    sh;
    logic [DW-1:0] q_req;
    logic [DW-1:0] q_trunc;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [ADW-1:0]  fa;
    logic [N*DW-1:0] fd;
    logic [DW-1:0]   eq;

    vecs[0]  = '{64'h0000_0000_0000_1230, 6'd4,  16'h0123, 16'h1230};
    vecs[1]  = '{64'h0000_0000_07FF_FFFF, 6'd4,  16'h7FFF, 16'hFFFF};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFB0, 6'd4,  16'hFFFB, 16'hFFB0};
    vecs[3]  = '{64'hFFFF_FF00_0000_0000, 6'd4,  16'h8000, 16'h0000};
    vecs[4]  = '{64'h0000_0000_1234_5678, 6'd4,  16'h7FFF, 16'h5678};
    vecs[5]  = '{64'hFFFF_FFFF_FFFF_FF00, 6'd63, 16'hFFFF, 16'hFF00};
    vecs[6]  = '{64'h0000_0000_0000_7FFF, 6'd0,  16'h7FFF, 16'h7FFF};
    vecs[7]  = '{64'h0000_0000_0000_8000, 6'd0,  16'h7FFF, 16'h8000};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_8000, 6'd0,  16'h8000, 16'h8000};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_7FFF, 6'd0,  16'h8000, 16'h7FFF};
    vecs[10] = '{64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 16'h0000, 16'hFFFF};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; shift = '0; bus.wr_ready = 1'b1;
    fill_pattern();
    #1;
    check("rst_drain_enable", 64'(bus.drain_enable), 64'd0);
    check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic drain, ready always high
    run_drain(16'h0010, 6'd0, -1, 0, 1'b0, 6, fa, fd);
    check("basic_first_addr", 64'(fa), 64'h0013);
    check("basic_first_data", 64'(fd), 64'h012F_012E_012D_012C);

    // Three-cycle stall on the second write
    run_drain(16'h0010, 6'd0, 1, 3, 1'b0, 9, fa, fd);

    // Address wrap
    run_drain(16'hFFFE, 6'd0, -1, 0, 1'b0, 6, fa, fd);
    check("wrap_first_addr", 64'(fa), 64'h0001);

    // Requant / truncation table
    for (int i = 0; i < 11; i++) begin
      fill_const(vecs[i].acc);
`ifdef DRAIN_REQUANT_EN
      eq = vecs[i].q_req;
`else
      eq = vecs[i].q_trunc;
`endif
      run_drain(16'h0040, vecs[i].sh, -1, 0, 1'b0, 6, fa, fd);
      check($sformatf("vec%0d_row", i), 64'(fd), {4{eq}});
    end

    // Stray starts are ignored, exactly one done
    fill_pattern();
    run_drain(16'h0030, 6'd0, -1, 0, 1'b1, 6, fa, fd);
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_after_stray_busy", 64'(busy), 64'd0);
      check("idle_after_stray_done", 64'(done), 64'd0);
    end

    // Back-to-back: start in the cycle right after done
    run_drain(16'h0050, 6'd0, -1, 0, 1'b0, 6, fa, fd);
    run_drain(16'h0060, 6'd0, -1, 0, 1'b0, 6, fa, fd);
    check("b2b_first_addr", 64'(fa), 64'h0063);

    // Async reset during the stall of the second write
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0020; shift = 6'd0; bus.wr_ready = 1'b1;
    @(negedge clk); start = 1'b0; bus.wr_ready = 1'b1;
    @(negedge clk); bus.wr_ready = 1'b1;
    @(negedge clk); bus.wr_ready = 1'b0;
    #1;
    check("pre_reset_wr_valid", 64'(bus.wr_valid), 64'd1);
    check("pre_reset_wr_addr", 64'(bus.wr_addr), 64'h0022);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_drain_enable", 64'(bus.drain_enable), 64'd0);
    check("mid_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("mid_rst_wr_data", 64'(bus.wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_pattern();
    run_drain(16'h0020, 6'd0, -1, 0, 1'b0, 6, fa, fd);
    check("post_reset_first_data", 64'(fd), 64'h012F_012E_012D_012C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
